// File: rtl/pwm_ramp_pkg.sv
// rtl/pwm_ramp_pkg.sv - shared types and helpers for the pwm threshold slew limiter
package pwm_ramp_pkg;

  typedef enum logic {IDLE, SCAN} state_t;

  localparam int max_ch    = 64;
  localparam int max_sel_w = 6;

  function automatic int sel_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic [max_ch-1:0] onehot(input logic [max_sel_w-1:0] i);
    logic [max_ch-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/pwm_ramp_if.sv
// rtl/pwm_ramp_if.sv - threshold write bus from the SPI command decode
interface pwm_ramp_if
  import pwm_ramp_pkg::*;
#(
  parameter int pwm_width  = 16,
  parameter int num_pwm    = 12,
  parameter int step_width = 8
) ();

  localparam int sel_w = sel_bits(num_pwm);

  logic                  wr_valid;
  logic [sel_w-1:0]      wr_sel;
  logic [pwm_width-1:0]  wr_target;
  logic [step_width-1:0] wr_step;

  modport master (output wr_valid, wr_sel, wr_target, wr_step);
  modport slave  (input  wr_valid, wr_sel, wr_target, wr_step);

endinterface

// File: rtl/pwm_ramp_step.sv
// rtl/pwm_ramp_step.sv - one saturating step of cur toward tgt, never overshooting or wrapping
module pwm_ramp_step #(
  parameter int pwm_width  = 16,
  parameter int step_width = 8
) (
  input  logic [pwm_width-1:0]  cur,
  input  logic [pwm_width-1:0]  tgt,
  input  logic [step_width-1:0] step,
  output logic [pwm_width-1:0]  next
);

  logic [pwm_width:0] step_ext;
  logic [pwm_width:0] sum;
  logic [pwm_width:0] diff;

  always_comb begin
    step_ext = {{(pwm_width + 1 - step_width){1'b0}}, step};
    sum      = {1'b0, cur} + step_ext;
    diff     = {1'b0, cur} - {1'b0, tgt};
    next     = cur;
    if (cur < tgt) begin
      next = (sum >= {1'b0, tgt}) ? tgt : sum[pwm_width-1:0];
    end else if (cur > tgt) begin
      next = (diff <= step_ext) ? tgt : cur - step_ext[pwm_width-1:0];
    end
  end

endmodule

// File: rtl/pwm_ramp.sv
// rtl/pwm_ramp.sv - per-channel threshold slew limiter feeding single-cycle writes to the pwm bank
module pwm_ramp
  import pwm_ramp_pkg::*;
#(
  parameter int pwm_width  = 16,
  parameter int num_pwm    = 12,
  parameter int step_width = 8
) (
  input  logic                 clk,
  input  logic                 nreset,
  pwm_ramp_if.slave            wr,
  input  logic                 overflow,
  output logic [num_pwm-1:0]   out_sel_onehot,
  output logic [pwm_width-1:0] out_thres,
  output logic                 busy
);

  localparam int sel_w = sel_bits(num_pwm);

  logic [num_pwm-1:0][pwm_width-1:0]  cur_q, cur_n, tgt_q, tgt_n;
  logic [num_pwm-1:0][step_width-1:0] step_q, step_n;
  logic [num_pwm-1:0]                 dirty_q, dirty_n;
  state_t                             state_q, state_n;
  logic [sel_w-1:0]                   idx_q, idx_n;
  logic                               sweep_pend_q, sweep_pend_n;
  logic [num_pwm-1:0]                 sel_n;
  logic [pwm_width-1:0]               thres_n;
  logic                               busy_n;

  logic               wr_ok;
  logic [num_pwm-1:0] wr_hit;
  logic               svc_any;
  logic [sel_w-1:0]   svc_idx;
  logic [pwm_width-1:0] step_next;

  assign wr_ok  = wr.wr_valid && (32'(wr.wr_sel) < 32'(num_pwm));
  assign wr_hit = num_pwm'(onehot(max_sel_w'(wr.wr_sel))) & {num_pwm{wr_ok}};

  pwm_ramp_step #(.pwm_width(pwm_width), .step_width(step_width)) u_step (
    .cur  (cur_q[idx_q]),
    .tgt  (tgt_q[idx_q]),
    .step (step_q[idx_q]),
    .next (step_next)
  );

  always_comb begin
    svc_any = 1'b0;
    svc_idx = '0;
    for (int i = num_pwm - 1; i >= 0; i--) begin
      if (dirty_q[i]) begin
        svc_any = 1'b1;
        svc_idx = sel_w'(i);
      end
    end
  end

  always_comb begin
    cur_n        = cur_q;
    tgt_n        = tgt_q;
    step_n       = step_q;
    dirty_n      = dirty_q;
    state_n      = state_q;
    idx_n        = idx_q;
    sweep_pend_n = sweep_pend_q;
    sel_n        = '0;
    thres_n      = '0;

    case (state_q)
      IDLE: begin
        // a sweep request outranks dirty service in the same cycle
        if (overflow || sweep_pend_q) begin
          state_n      = SCAN;
          idx_n        = '0;
          sweep_pend_n = 1'b0;
        end else if (svc_any) begin
          sel_n            = num_pwm'(onehot(max_sel_w'(svc_idx)));
          thres_n          = cur_q[svc_idx];
          dirty_n[svc_idx] = 1'b0;
        end
      end
      SCAN: begin
        if (overflow) sweep_pend_n = 1'b1;
        if (!wr_hit[idx_q]) begin
          if (cur_q[idx_q] != tgt_q[idx_q]) begin
            cur_n[idx_q] = step_next;
            sel_n        = num_pwm'(onehot(max_sel_w'(idx_q)));
            thres_n      = step_next;
          end else if (dirty_q[idx_q]) begin
            sel_n   = num_pwm'(onehot(max_sel_w'(idx_q)));
            thres_n = cur_q[idx_q];
          end
          dirty_n[idx_q] = 1'b0;
        end
        if (idx_q == sel_w'(num_pwm - 1)) begin
          // a pending sweep restarts back-to-back with no idle gap
          if (overflow || sweep_pend_q) begin
            idx_n        = '0;
            sweep_pend_n = 1'b0;
          end else begin
            state_n = IDLE;
          end
        end else begin
          idx_n = idx_q + sel_w'(1);
        end
      end
      default: state_n = IDLE;
    endcase

    for (int i = 0; i < num_pwm; i++) begin
      if (wr_hit[i]) begin
        tgt_n[i]  = wr.wr_target;
        step_n[i] = wr.wr_step;
        if (wr.wr_step == '0) begin
          cur_n[i]   = wr.wr_target;
          dirty_n[i] = 1'b1;
        end
      end
    end

    busy_n = (state_n == SCAN) || (|dirty_n);
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      cur_q          <= '0;
      tgt_q          <= '0;
      step_q         <= '0;
      dirty_q        <= '0;
      state_q        <= IDLE;
      idx_q          <= '0;
      sweep_pend_q   <= 1'b0;
      out_sel_onehot <= '0;
      out_thres      <= '0;
      busy           <= 1'b0;
    end else begin
      cur_q          <= cur_n;
      tgt_q          <= tgt_n;
      step_q         <= step_n;
      dirty_q        <= dirty_n;
      state_q        <= state_n;
      idx_q          <= idx_n;
      sweep_pend_q   <= sweep_pend_n;
      out_sel_onehot <= sel_n;
      out_thres      <= thres_n;
      busy           <= busy_n;
    end
  end

endmodule

// File: tb/tb_pwm_ramp.sv
// tb/tb_pwm_ramp.sv - self-checking bench for pwm_ramp: vector table, corner sequences, random vs reference model
module tb_pwm_ramp;
  import pwm_ramp_pkg::*;

  localparam int pw    = 16;
  localparam int np    = 12;
  localparam int sw    = 8;
  localparam int sel_w = sel_bits(np);

  logic          clk = 1'b0;
  logic          nreset = 1'b0;
  logic          overflow = 1'b0;
  logic [np-1:0] out_sel_onehot;
  logic [pw-1:0] out_thres;
  logic          busy;

  int n_checks = 0;
  int n_fail   = 0;

  pwm_ramp_if #(.pwm_width(pw), .num_pwm(np), .step_width(sw)) wr_if ();

  pwm_ramp #(.pwm_width(pw), .num_pwm(np), .step_width(sw)) dut (
    .clk            (clk),
    .nreset         (nreset),
    .wr             (wr_if),
    .overflow       (overflow),
    .out_sel_onehot (out_sel_onehot),
    .out_thres      (out_thres),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  // reference model: thresholds as plain integers, sweep position -1 when idle
  int            m_cur [np];
  int            m_tgt [np];
  int            m_step[np];
  bit            m_dirty[np];
  int            m_pos = -1;
  bit            m_pend = 1'b0;
  logic [np-1:0] e_sel;
  logic [pw-1:0] e_thr;
  logic          e_busy;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_eval(input bit v, input int sel, input int tgt, input int stp,
                            input bit ovf, input bit rn);
    int  c, nv, lo;
    bit  wr_ok;
    e_sel = '0;
    e_thr = '0;
    if (!rn) begin
      for (int i = 0; i < np; i++) begin
        m_cur[i] = 0; m_tgt[i] = 0; m_step[i] = 0; m_dirty[i] = 0;
      end
      m_pos  = -1;
      m_pend = 0;
      e_busy = 0;
      return;
    end
    wr_ok = v && (sel < np);
    if (m_pos < 0) begin
      if (ovf || m_pend) begin
        m_pos  = 0;
        m_pend = 0;
      end else begin
        lo = -1;
        for (int i = np - 1; i >= 0; i--) if (m_dirty[i]) lo = i;
        if (lo >= 0) begin
          e_sel = np'(1) << lo;
          e_thr = pw'(m_cur[lo]);
          m_dirty[lo] = 0;
        end
      end
    end else begin
      c = m_pos;
      if (ovf) m_pend = 1;
      if (!(wr_ok && sel == c)) begin
        if (m_cur[c] != m_tgt[c]) begin
          if (m_cur[c] < m_tgt[c])
            nv = (m_cur[c] + m_step[c] > m_tgt[c]) ? m_tgt[c] : m_cur[c] + m_step[c];
          else
            nv = (m_cur[c] - m_step[c] < m_tgt[c]) ? m_tgt[c] : m_cur[c] - m_step[c];
          m_cur[c] = nv;
          e_sel = np'(1) << c;
          e_thr = pw'(nv);
        end else if (m_dirty[c]) begin
          e_sel = np'(1) << c;
          e_thr = pw'(m_cur[c]);
        end
        m_dirty[c] = 0;
      end
      if (c == np - 1) begin
        m_pos  = m_pend ? 0 : -1;
        m_pend = 0;
      end else begin
        m_pos = c + 1;
      end
    end
    if (wr_ok) begin
      m_tgt[sel]  = tgt;
      m_step[sel] = stp;
      if (stp == 0) begin
        m_cur[sel]   = tgt;
        m_dirty[sel] = 1;
      end
    end
    e_busy = (m_pos >= 0);
    for (int i = 0; i < np; i++) if (m_dirty[i]) e_busy = 1;
  endtask

  task automatic tick(input bit v, input int sel, input int tgt, input int stp,
                      input bit ovf, input bit rn);
    wr_if.wr_valid  = v;
    wr_if.wr_sel    = sel_w'(sel);
    wr_if.wr_target = pw'(tgt);
    wr_if.wr_step   = sw'(stp);
    overflow        = ovf;
    nreset          = rn;
    model_eval(v, sel, tgt, stp, ovf, rn);
    @(posedge clk);
    #1;
    chk("model_sel",  32'(out_sel_onehot), 32'(e_sel));
    chk("model_thr",  32'(out_thres),      32'(e_thr));
    chk("model_busy", 32'(busy),           32'(e_busy));
    wr_if.wr_valid = 1'b0;
    overflow       = 1'b0;
    nreset         = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(0, 0, 0, 0, 0, 1);
  endtask

  typedef struct {
    bit            rn;
    bit            v;
    int            sel;
    int            tgt;
    int            stp;
    bit            ovf;
    logic [np-1:0] e_sel;
    int            e_thr;
    bit            e_busy;
  } vec_t;

  vec_t vt[$];
  int   got_thr[$];
  int   got_cyc[$];
  int   exp_ramp[4];
  int   n_strobe, strobe_at, busy_cnt;
  logic [np-1:0] last_sel;
  int   last_thr;
  bit   r_v, r_ovf, r_rn;
  int   r_sel, r_tgt, r_stp;

  initial begin
    wr_if.wr_valid  = 1'b0;
    wr_if.wr_sel    = '0;
    wr_if.wr_target = '0;
    wr_if.wr_step   = '0;

    // immediate writes, priority among dirty channels, invalid selects
    vt.push_back('{0, 0,  0,      0, 0, 0, 12'h000,      0, 0});
    vt.push_back('{1, 0,  0,      0, 0, 0, 12'h000,      0, 0});
    vt.push_back('{1, 1,  3, 'h1234, 0, 0, 12'h000,      0, 1});
    vt.push_back('{1, 0,  0,      0, 0, 0, 12'h008, 'h1234, 0});
    vt.push_back('{1, 0,  0,      0, 0, 0, 12'h000,      0, 0});
    vt.push_back('{1, 1, 12, 'hffff, 0, 0, 12'h000,      0, 0});
    vt.push_back('{1, 0,  0,      0, 0, 0, 12'h000,      0, 0});
    vt.push_back('{1, 1, 15,  'h500, 5, 0, 12'h000,      0, 0});
    vt.push_back('{1, 1, 11, 'habcd, 0, 0, 12'h000,      0, 1});
    vt.push_back('{1, 1,  2,      7, 0, 0, 12'h800, 'habcd, 1});
    vt.push_back('{1, 0,  0,      0, 0, 0, 12'h004,      7, 0});
    vt.push_back('{1, 0,  0,      0, 0, 0, 12'h000,      0, 0});
    foreach (vt[i]) begin
      tick(vt[i].v, vt[i].sel, vt[i].tgt, vt[i].stp, vt[i].ovf, vt[i].rn);
      chk($sformatf("tbl%0d_sel", i),  32'(out_sel_onehot), 32'(vt[i].e_sel));
      chk($sformatf("tbl%0d_thr", i),  32'(out_thres),      32'(vt[i].e_thr));
      chk($sformatf("tbl%0d_busy", i), 32'(busy),           32'(vt[i].e_busy));
    end

    // invalid selects left every channel settled: a sweep writes nothing
    tick(0, 0, 0, 0, 1, 1);
    n_strobe = 0;
    for (int c = 0; c < np + 2; c++) begin
      idle(1);
      if (out_sel_onehot != 0) n_strobe++;
    end
    chk("invalid_sweep_strobes", 32'(n_strobe), 0);
    chk("invalid_busy_after", 32'(busy), 0);

    // ramp up 0 -> 100 in steps of 30
    tick(0, 0, 0, 0, 0, 0);
    tick(1, 0, 100, 30, 0, 1);
    idle(3);
    got_thr.delete();
    for (int s = 0; s < 5; s++) begin
      tick(0, 0, 0, 0, 1, 1);
      for (int c = 0; c < np + 2; c++) begin
        idle(1);
        if (c == 0) chk($sformatf("ramp%0d_slot", s), 32'(out_sel_onehot), (s < 4) ? 1 : 0);
        if (out_sel_onehot == 12'h001) got_thr.push_back(int'(out_thres));
      end
    end
    exp_ramp = '{30, 60, 90, 100};
    chk("ramp_count", 32'(got_thr.size()), 4);
    for (int i = 0; i < 4; i++)
      chk($sformatf("ramp_val%0d", i), (i < got_thr.size()) ? 32'(got_thr[i]) : 32'hffffffff,
          32'(exp_ramp[i]));

    // saturating ramp down from 100 with step 255
    tick(0, 0, 0, 0, 0, 0);
    tick(1, 5, 100, 0, 0, 1);
    idle(2);
    tick(1, 5, 0, 255, 0, 1);
    idle(1);
    tick(0, 0, 0, 0, 1, 1);
    n_strobe = 0; strobe_at = -1; last_sel = '0; last_thr = -1;
    for (int c = 1; c <= np + 2; c++) begin
      idle(1);
      if (out_sel_onehot != 0) begin
        n_strobe++; strobe_at = c; last_sel = out_sel_onehot; last_thr = int'(out_thres);
      end
    end
    chk("down_count", 32'(n_strobe), 1);
    chk("down_edge",  32'(strobe_at), 6);
    chk("down_sel",   32'(last_sel), 32'h020);
    chk("down_thr",   32'(last_thr), 0);

    // three overflows inside one sweep merge into one back-to-back extra sweep
    tick(0, 0, 0, 0, 0, 0);
    tick(1, 0, 1000, 1, 0, 1);
    idle(2);
    tick(0, 0, 0, 0, 1, 1);
    got_cyc.delete(); got_thr.delete(); busy_cnt = 0;
    for (int c = 1; c <= 30; c++) begin
      tick(0, 0, 0, 0, (c == 3 || c == 5 || c == 8), 1);
      if (out_sel_onehot != 0) begin
        got_cyc.push_back(c);
        got_thr.push_back(int'(out_thres));
      end
      if (busy) busy_cnt++;
    end
    chk("merge_count", 32'(got_cyc.size()), 2);
    chk("merge_first",  (got_cyc.size() > 0) ? 32'(got_cyc[0]) : 32'hffffffff, 1);
    chk("merge_second", (got_cyc.size() > 1) ? 32'(got_cyc[1]) : 32'hffffffff, np + 1);
    chk("merge_thr2",   (got_thr.size() > 1) ? 32'(got_thr[1]) : 32'hffffffff, 2);
    chk("merge_busy_cycles", 32'(busy_cnt), 2 * np - 1);

    // reset in the middle of a sweep, at the cycle channel 4 is scanned
    tick(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < np; i++) tick(1, i, 500, 10, 0, 1);
    idle(1);
    tick(0, 0, 0, 0, 1, 1);
    idle(4);
    tick(0, 0, 0, 0, 0, 0);
    chk("rst_mid_sel",  32'(out_sel_onehot), 0);
    chk("rst_mid_thr",  32'(out_thres), 0);
    chk("rst_mid_busy", 32'(busy), 0);
    tick(0, 0, 0, 0, 1, 1);
    n_strobe = 0;
    for (int c = 0; c < np + 4; c++) begin
      idle(1);
      if (out_sel_onehot != 0) n_strobe++;
    end
    chk("rst_after_strobes", 32'(n_strobe), 0);

    // randomized traffic against the model
    tick(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      r_v   = ($urandom_range(0, 3) == 0);
      r_sel = $urandom_range(0, 15);
      r_tgt = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 65535) : $urandom_range(0, 600);
      r_stp = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 255);
      r_ovf = ($urandom_range(0, 24) == 0);
      r_rn  = ($urandom_range(0, 999) != 0);
      tick(r_v, r_sel, r_tgt, r_stp, r_ovf, r_rn);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
